// File: rtl/seg7_pkg.sv
// Shared types, constants and helpers for the multiplexed seven-segment driver.
// Latency: combinational helpers only.
// Backpressure: none; pure functions with no flow control.
package seg7_pkg;

  // All segments off (active-low pins).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Widest anode vector the helper can build; callers size-cast down to their digit count.
  localparam int MAX_DIGITS = 32;

  // Hex nibble to active-low segment pattern, bit order {A,B,C,D,E,F,G}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      4'hF: s = 7'b0111000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Active-low anode vector with only bit idx low; out-of-range idx gives all ones.
  function automatic logic [MAX_DIGITS-1:0] digit_onehot_n(input int idx, input int n);
    logic [MAX_DIGITS-1:0] v;
    v = '1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i == idx && i < n) v[i] = 1'b0;
    end
    return v;
  endfunction

endpackage

// File: rtl/seg7_refresh_timer.sv
// Scan timebase: slot counter, digit index and end-of-frame pulse.
// Latency: frame_done is high the cycle after dig_idx wraps to 0; wrap is combinational.
// Backpressure: none; free-running counters.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   slot_cnt            position within the current digit slot, 0..REFRESH_DIV-1
//   dig_idx             digit currently being scanned, 0..NUM_DIGITS-1
//   wrap                high in the last cycle of a slot
//   frame_done          one-cycle pulse after the scan returns to digit 0
module seg7_refresh_timer #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int SLOT_W      = 17,
  parameter int IDX_W       = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [SLOT_W-1:0] slot_cnt,
  output logic [IDX_W-1:0]  dig_idx,
  output logic              wrap,
  output logic              frame_done
);

  assign wrap = (slot_cnt == SLOT_W'(REFRESH_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt   <= '0;
      dig_idx    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (wrap) begin
        slot_cnt <= '0;
        // With a single digit this compare is always true, so dig_idx stays 0
        // and frame_done fires once per slot.
        if (dig_idx == IDX_W'(NUM_DIGITS - 1)) begin
          dig_idx    <= '0;
          frame_done <= 1'b1;
        end else begin
          dig_idx <= dig_idx + IDX_W'(1);
        end
      end else begin
        slot_cnt <= slot_cnt + SLOT_W'(1);
      end
    end
  end

endmodule

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed N-digit seven-segment driver with blanking, leading-zero suppression and PWM brightness.
// Latency: pins at edge t+1 reflect counters/shadow after edge t; a load at edge t is visible at t+1.
// Backpressure: none; load is a one-cycle strobe with no handshake, the scan never stalls.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   value               packed hex nibbles, digit 0 in bits [3:0] (rightmost)
//   dp_in, blank        per-digit decimal-point request / force-dark mask
//   lz_suppress         darken leading zero digits (digit 0 is never suppressed)
//   brightness          duty level, 0 = dark, all ones = full (sampled live)
//   load                captures value/dp_in/blank into the shadow registers
//   seg, dp, an         active-low segment, decimal point and anode pins
//   frame_done          one-cycle pulse when the scan wraps to digit 0
module seg7_mux_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BRIGHT_W    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    lz_suppress,
  input  logic [BRIGHT_W-1:0]     brightness,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  // Slot cycles gained per brightness step.
  localparam int STEP   = REFRESH_DIV >> BRIGHT_W;

  logic [SLOT_W-1:0]       slot_cnt;
  logic [IDX_W-1:0]        dig_idx;
  // The output stage works purely from slot_cnt, so the slot-wrap strobe is not needed here.
  logic                    wrap_unused;

  logic [4*NUM_DIGITS-1:0] sh_value;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blank;

  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic                    cur_zero_up;
  logic                    cur_supp;
  logic [SLOT_W:0]         on_thr;
  logic                    active;
  logic                    dark;

  seg7_refresh_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .SLOT_W      (SLOT_W),
    .IDX_W       (IDX_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .slot_cnt   (slot_cnt),
    .dig_idx    (dig_idx),
    .wrap       (wrap_unused),
    .frame_done (frame_done)
  );

  // Shadow registers: the datapath may change value freely; only a load strobe updates the display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_value <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
    end else if (load) begin
      sh_value <= value;
      sh_dp    <= dp_in;
      sh_blank <= blank;
    end
  end

  // Select the shadow fields of the digit being scanned. cur_zero_up is true when this
  // digit and every more-significant digit hold 0, i.e. it is a leading zero.
  always_comb begin
    cur_nib     = '0;
    cur_dp      = 1'b0;
    cur_blank   = 1'b0;
    cur_zero_up = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_idx == IDX_W'(i)) begin
        cur_nib     = sh_value[4*i +: 4];
        cur_dp      = sh_dp[i];
        cur_blank   = sh_blank[i];
        cur_zero_up = ((sh_value >> (4*i)) == '0);
      end
    end
  end

  always_comb begin
    cur_supp = lz_suppress && (dig_idx != '0) && cur_zero_up;
    on_thr   = (SLOT_W+1)'((int'(brightness) + 1) * STEP);
    // slot_cnt == 0 is kept dark in every slot so the anode switch never overlaps
    // the previous digit's segments (anti-ghosting).
    active   = (brightness != '0) && (slot_cnt != '0) && ({1'b0, slot_cnt} < on_thr);
    dark     = cur_blank || cur_supp || !active;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_BLANK;
      dp  <= 1'b1;
      an  <= '1;
    end else if (dark) begin
      seg <= SEG_BLANK;
      dp  <= 1'b1;
      an  <= '1;
    end else begin
      seg <= hex_to_seg(cur_nib);
      dp  <= ~cur_dp;
      an  <= NUM_DIGITS'(digit_onehot_n(int'(dig_idx), NUM_DIGITS));
    end
  end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Bench for seg7_mux_driver with 4 digits, 8-cycle slots, 3-bit brightness.
// Reference model: the scan position is derived from the number of clock edges since reset.
module tb_seg7_mux_driver;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int FRAME = ND * RD;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
  logic        lz_suppress;
  logic [2:0]  brightness;
  logic        load;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int fails  = 0;

  // Model state: edges since reset release plus the shadowed display data.
  int          m_n;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic [3:0]  m_blk;
  // Expected pins after the most recent tick.
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_an;
  logic        e_fd;
  logic        e_lit;

  always #5 clk = ~clk;

  seg7_mux_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BRIGHT_W(3)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .blank(blank),
    .lz_suppress(lz_suppress), .brightness(brightness), .load(load),
    .seg(seg), .dp(dp), .an(an), .frame_done(frame_done));

  task automatic model_reset();
    m_n = 0; m_val = '0; m_dp = '0; m_blk = '0;
  endtask

  // Advance one clock. Pins after this edge come from the state before it and
  // the live brightness / lz_suppress; the shadow takes a load at this edge.
  task automatic tick();
    int slot, dig;
    logic [3:0] nib;
    logic lit;
    slot = m_n % RD;
    dig  = (m_n / RD) % ND;
    nib  = m_val[4*dig +: 4];
    lit  = (brightness != 0) && (slot >= 1) && (slot < (int'(brightness) + 1) * (RD / 8));
    if (m_blk[dig]) lit = 1'b0;
    if (lz_suppress && dig > 0 && (m_val >> (4*dig)) == 16'h0) lit = 1'b0;
    if (lit) begin
      e_seg = SEG_TAB[nib]; e_dp = ~m_dp[dig]; e_an = ~(4'b0001 << dig);
    end else begin
      e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
    end
    e_lit = lit;
    @(posedge clk);
    m_n++;
    if (load) begin m_val = value; m_dp = dp_in; m_blk = blank; end
    e_fd = (m_n % FRAME == 0);
    #1;
  endtask

  task automatic load_data(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value = v; dp_in = d; blank = b; load = 1'b1;
    tick();
    checks++;
    if ({seg, dp, an, frame_done} !== {e_seg, e_dp, e_an, e_fd}) begin
      fails++;
      $display("FAIL load n=%0d: seg=%b dp=%b an=%b fd=%b, want seg=%b dp=%b an=%b fd=%b",
               m_n, seg, dp, an, frame_done, e_seg, e_dp, e_an, e_fd);
    end
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; value = '0; dp_in = '0; blank = '0; lz_suppress = 1'b0;
    brightness = '0; load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({seg, dp, an, frame_done} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
      fails++;
      $display("FAIL reset_hold: seg=%b dp=%b an=%b fd=%b, want seg=1111111 dp=1 an=1111 fd=0",
               seg, dp, an, frame_done);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_hex_scan();
    int lit_cnt [4];
    int fd_cnt;
    brightness = 3'd7; lz_suppress = 1'b0;
    load_data(16'h12AF, 4'b0000, 4'b0000);
    repeat (FRAME) begin
      if (m_n % FRAME != 0) tick();
    end
    foreach (lit_cnt[i]) lit_cnt[i] = 0;
    fd_cnt = 0;
    repeat (2 * FRAME) begin
      tick();
      checks++;
      if ({seg, dp, an, frame_done} !== {e_seg, e_dp, e_an, e_fd}) begin
        fails++;
        $display("FAIL hex_scan n=%0d: seg=%b dp=%b an=%b fd=%b, want seg=%b dp=%b an=%b fd=%b",
                 m_n, seg, dp, an, frame_done, e_seg, e_dp, e_an, e_fd);
      end
      for (int d = 0; d < ND; d++) if (an === ~(4'b0001 << d)) lit_cnt[d]++;
      if (frame_done === 1'b1) fd_cnt++;
    end
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (lit_cnt[d] != 14) begin
        fails++;
        $display("FAIL hex_scan_duty digit %0d: lit %0d cycles in two frames, want 14", d, lit_cnt[d]);
      end
    end
    checks++;
    if (fd_cnt != 2) begin
      fails++;
      $display("FAIL frame_done_rate: %0d pulses in 64 cycles, want 2", fd_cnt);
    end
  endtask

  task automatic test_lz_suppress();
    int hi_lit;
    lz_suppress = 1'b1; brightness = 3'd7;
    load_data(16'h0050, 4'b0000, 4'b0000);
    hi_lit = 0;
    repeat (FRAME) begin
      tick();
      checks++;
      if ({seg, dp, an, frame_done} !== {e_seg, e_dp, e_an, e_fd}) begin
        fails++;
        $display("FAIL lz_0050 n=%0d: seg=%b dp=%b an=%b fd=%b, want seg=%b dp=%b an=%b fd=%b",
                 m_n, seg, dp, an, frame_done, e_seg, e_dp, e_an, e_fd);
      end
      if (an[3] === 1'b0 || an[2] === 1'b0) hi_lit++;
    end
    checks++;
    if (hi_lit != 0) begin
      fails++;
      $display("FAIL lz_upper_dark: digits 3/2 lit %0d cycles, want 0", hi_lit);
    end
    load_data(16'h0000, 4'b0000, 4'b0000);
    repeat (FRAME) begin
      tick();
      checks++;
      if ({seg, dp, an, frame_done} !== {e_seg, e_dp, e_an, e_fd}) begin
        fails++;
        $display("FAIL lz_0000 n=%0d: seg=%b dp=%b an=%b fd=%b, want seg=%b dp=%b an=%b fd=%b",
                 m_n, seg, dp, an, frame_done, e_seg, e_dp, e_an, e_fd);
      end
    end
    lz_suppress = 1'b0;
  endtask

  task automatic test_brightness();
    load_data(16'h12AF, 4'b0000, 4'b0000);
    for (int b = 0; b < 8; b++) begin
      brightness = 3'(b);
      repeat (FRAME) begin
        tick();
        checks++;
        if ({seg, dp, an, frame_done} !== {e_seg, e_dp, e_an, e_fd}) begin
          fails++;
          $display("FAIL brightness_%0d n=%0d: seg=%b dp=%b an=%b fd=%b, want seg=%b dp=%b an=%b fd=%b",
                   b, m_n, seg, dp, an, frame_done, e_seg, e_dp, e_an, e_fd);
        end
      end
    end
  endtask

  task automatic test_dp_blank_hold();
    brightness = 3'd7;
    load_data(16'h12AF, 4'b0100, 4'b0001);
    // Later half of the loop changes inputs without load: the display must not follow.
    for (int c = 0; c < 2 * FRAME; c++) begin
      if (c == FRAME) begin value = 16'hFFFF; dp_in = 4'b1011; blank = 4'b1110; end
      tick();
      checks++;
      if ({seg, dp, an, frame_done} !== {e_seg, e_dp, e_an, e_fd}) begin
        fails++;
        $display("FAIL dp_blank c=%0d: seg=%b dp=%b an=%b fd=%b, want seg=%b dp=%b an=%b fd=%b",
                 c, seg, dp, an, frame_done, e_seg, e_dp, e_an, e_fd);
      end
    end
  endtask

  task automatic test_midslot_load();
    brightness = 3'd7;
    load_data(16'h12AF, 4'b0000, 4'b0000);
    // Next edge then sees digit 1 at slot position 3.
    repeat (FRAME) begin
      if (m_n % FRAME != RD + 3) tick();
    end
    load_data(16'h1234, 4'b0000, 4'b0000);
    tick();
    checks++;
    if (seg !== SEG_TAB[3] || an !== 4'b1101) begin
      fails++;
      $display("FAIL midslot_load: seg=%b an=%b, want seg=%b an=1101", seg, an, SEG_TAB[3]);
    end
    // Load coincident with a slot wrap: the new digit shows the new data.
    repeat (RD) begin
      if (m_n % RD != RD - 1) tick();
    end
    load_data(16'h9876, 4'b0011, 4'b0000);
    repeat (RD) begin
      tick();
      checks++;
      if ({seg, dp, an, frame_done} !== {e_seg, e_dp, e_an, e_fd}) begin
        fails++;
        $display("FAIL wrap_load n=%0d: seg=%b dp=%b an=%b fd=%b, want seg=%b dp=%b an=%b fd=%b",
                 m_n, seg, dp, an, frame_done, e_seg, e_dp, e_an, e_fd);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 7) == 0) brightness = 3'($urandom);
      if ($urandom_range(0, 15) == 0) lz_suppress = 1'($urandom);
      value = 16'($urandom);
      if ($urandom_range(0, 2) == 0) value = value & 16'h00FF;
      dp_in = 4'($urandom);
      blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      load  = ($urandom_range(0, 9) == 0);
      tick();
      checks++;
      if ({seg, dp, an, frame_done} !== {e_seg, e_dp, e_an, e_fd}) begin
        fails++;
        $display("FAIL random c=%0d: seg=%b dp=%b an=%b fd=%b, want seg=%b dp=%b an=%b fd=%b",
                 c, seg, dp, an, frame_done, e_seg, e_dp, e_an, e_fd);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_async_reset();
    brightness = 3'd7; lz_suppress = 1'b0;
    load_data(16'h8888, 4'b1111, 4'b0000);
    repeat (RD) begin
      if (!e_lit) tick();
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({seg, dp, an, frame_done} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
      fails++;
      $display("FAIL async_reset: seg=%b dp=%b an=%b fd=%b, want seg=1111111 dp=1 an=1111 fd=0",
               seg, dp, an, frame_done);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    // Shadow must come back cleared: digit 0 shows 0, the rest follow the model.
    repeat (FRAME) begin
      tick();
      checks++;
      if ({seg, dp, an, frame_done} !== {e_seg, e_dp, e_an, e_fd}) begin
        fails++;
        $display("FAIL post_reset n=%0d: seg=%b dp=%b an=%b fd=%b, want seg=%b dp=%b an=%b fd=%b",
                 m_n, seg, dp, an, frame_done, e_seg, e_dp, e_an, e_fd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hex_scan();
    test_lz_suppress();
    test_brightness();
    test_dp_blank_hold();
    test_midslot_load();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
